// File: rtl/adt7420_pkg.sv
// Shared types and register map for the ADT7420 I2C responder.
// Holds the FSM state enum, register pointers and read-mux helper.
package adt7420_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK
   } state_e;

   localparam logic [7:0] REG_TEMP_MSB = 8'h00;
   localparam logic [7:0] REG_TEMP_LSB = 8'h01;
   localparam logic [7:0] REG_STATUS   = 8'h02;
   localparam logic [7:0] REG_CONFIG   = 8'h03;
   localparam logic [7:0] REG_ID       = 8'h0B;

   // RDY_n is never driven low, so status reads as a constant
   localparam logic [7:0] STATUS_VAL   = 8'h80;

   function automatic logic [7:0] reg_read(
      input logic [7:0]  ptr,
      input logic [15:0] shadow,
      input logic [7:0]  cfg,
      input logic [7:0]  id
   );
      logic [7:0] v;
      v = 8'h00;
      case (ptr)
         REG_TEMP_MSB: v = shadow[15:8];
         REG_TEMP_LSB: v = shadow[7:0];
         REG_STATUS:   v = STATUS_VAL;
         REG_CONFIG:   v = cfg;
         REG_ID:       v = id;
         default:      v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into the clock domain and derives
// SCL edges plus START/STOP pulses from the synchronized lines.
module i2c_bus_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_hist_q;
   logic       sda_hist_q;
   logic       scl_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   assign scl_s      = scl_sync_q[1];
   assign sda_o      = sda_sync_q[1];
   assign scl_rise_o = scl_s & ~scl_hist_q;
   assign scl_fall_o = ~scl_s & scl_hist_q;
   assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_o;
   assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_o;

endmodule

// File: rtl/adt7420_i2c_responder.sv
// I2C target emulating the ADT7420 register interface: temperature,
// status, configuration and ID registers behind an 8-bit pointer.
module adt7420_i2c_responder
   import adt7420_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = 7'h4B,
   parameter logic [7:0] DEVICE_ID = 8'hCB
) (
   input  logic        clk_100MHz,
   input  logic        rst_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_pull_low,
   input  logic [15:0] temp_word,
   output logic [7:0]  config_reg,
   output logic        busy
);

   logic sda_s, scl_rise, scl_fall, start, stop;

   i2c_bus_sync u_sync (
      .clk_i      (clk_100MHz),
      .rst_ni     (rst_n),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop)
   );

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  sr_q, sr_d;
   logic        full_q, full_d;
   logic [7:0]  ptr_q, ptr_d;
   logic [15:0] shadow_q, shadow_d;
   logic [7:0]  cfg_q, cfg_d;
   logic        pull_q, pull_d;
   logic        busy_q, busy_d;
   logic [7:0]  ptr_nx;

   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         sr_q     <= 8'h00;
         full_q   <= 1'b0;
         ptr_q    <= 8'h00;
         shadow_q <= 16'h0000;
         cfg_q    <= 8'h00;
         pull_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         full_q   <= full_d;
         ptr_q    <= ptr_d;
         shadow_q <= shadow_d;
         cfg_q    <= cfg_d;
         pull_q   <= pull_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      full_d   = full_q;
      ptr_d    = ptr_q;
      shadow_d = shadow_q;
      cfg_d    = cfg_q;
      pull_d   = pull_q;
      busy_d   = busy_q;
      ptr_nx   = ptr_q;
      if (start) begin
         state_d = ADDR;
         cnt_d   = 3'd0;
         full_d  = 1'b0;
         pull_d  = 1'b0;
         busy_d  = 1'b1;
      end else if (stop) begin
         state_d = IDLE;
         full_d  = 1'b0;
         pull_d  = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  sr_d   = {sr_q[6:0], sda_s};
                  cnt_d  = cnt_q + 3'd1;
                  full_d = (cnt_q == 3'd7);
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  cnt_d  = 3'd0;
                  pull_d = 1'b1;
                  if (state_q == ADDR) begin
                     if (sr_q[7:1] == DEV_ADDR) begin
                        state_d = ADDR_ACK;
                     end else begin
                        state_d = IDLE;
                        pull_d  = 1'b0;
                     end
                  end else if (state_q == PTR) begin
                     ptr_d   = sr_q;
                     state_d = PTR_ACK;
                  end else begin
                     if (ptr_q == REG_CONFIG) cfg_d = sr_q;
                     state_d = WDATA_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 3'd0;
                  if (sr_q[0]) begin
                     // snapshot so MSB/LSB of one read burst are coherent
                     shadow_d = temp_word;
                     sr_d     = reg_read(ptr_q, temp_word, cfg_q, DEVICE_ID);
                     pull_d   = ~sr_d[7];
                     state_d  = RDATA;
                  end else begin
                     pull_d  = 1'b0;
                     state_d = PTR;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  pull_d  = 1'b0;
                  cnt_d   = 3'd0;
                  state_d = WDATA;
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     pull_d  = 1'b0;
                     full_d  = 1'b0;
                     state_d = RACK;
                  end else begin
                     sr_d   = {sr_q[6:0], 1'b1};
                     pull_d = ~sr_q[6];
                     cnt_d  = cnt_q + 3'd1;
                  end
               end
            end
            RACK: begin
               if (scl_rise) begin
                  sr_d   = {sr_q[6:0], sda_s};
                  full_d = 1'b1;
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  if (!sr_q[0]) begin
                     if (ptr_q == REG_TEMP_MSB) ptr_nx = REG_TEMP_LSB;
                     ptr_d   = ptr_nx;
                     sr_d    = reg_read(ptr_nx, shadow_q, cfg_q, DEVICE_ID);
                     pull_d  = ~sr_d[7];
                     cnt_d   = 3'd0;
                     state_d = RDATA;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      sda_pull_low = pull_q;
      busy         = busy_q;
      config_reg   = cfg_q;
   end

endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// Directed bench for adt7420_i2c_responder driving a bit-banged
// I2C controller on a wired-AND SDA line.
module tb_adt7420_i2c_responder;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl = 1'b1;
   logic        sda_drv = 1'b1;
   logic        sda_pull_low;
   logic        busy;
   logic [15:0] temp_word = 16'h0C80;
   logic [7:0]  config_reg;
   logic        sda_bus;

   int n_checks = 0;
   int n_fail = 0;

   assign sda_bus = sda_drv & ~sda_pull_low;

   always #5 clk = ~clk;

   adt7420_i2c_responder dut (
      .clk_100MHz   (clk),
      .rst_n        (rst_n),
      .scl_in       (scl),
      .sda_in       (sda_bus),
      .sda_pull_low (sda_pull_low),
      .temp_word    (temp_word),
      .config_reg   (config_reg),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic qw();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; qw();
      scl = 1'b1;     qw();
      sda_drv = 1'b0; qw();
      scl = 1'b0;     qw();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; qw();
      scl = 1'b1;     qw();
      sda_drv = 1'b1; qw();
   endtask

   task automatic wbit(input logic b);
      sda_drv = b; qw();
      scl = 1'b1;  qw(); qw();
      scl = 1'b0;  qw();
   endtask

   task automatic rbit(output logic b);
      sda_drv = 1'b1; qw();
      scl = 1'b1;     qw();
      b = sda_bus;    qw();
      scl = 1'b0;     qw();
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(ack);
   endtask

   task automatic rbyte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) rbit(d[i]);
      wbit(nack);
   endtask

   task automatic read_ptr(input logic [7:0] ptr, input logic [7:0] exp,
                           input string tag);
      logic       a;
      logic [7:0] d;
      i2c_start();
      wbyte(8'h96, a);
      wbyte(ptr, a);
      check({tag, "_ptr_ack"}, a, 1'b0);
      i2c_start();
      wbyte(8'h97, a);
      rbyte(d, 1'b1);
      check(tag, d, exp);
      i2c_stop();
   endtask

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a;
      logic [7:0] d;
      repeat (4) @(posedge clk);
      #1;
      check("rst_pull", sda_pull_low, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cfg", config_reg, 8'h00);
      rst_n = 1'b1;
      qw();

      i2c_start();
      check("busy_start", busy, 1'b1);
      wbyte(8'h96, a); check("cfgw_addr_ack", a, 1'b0);
      wbyte(8'h03, a); check("cfgw_ptr_ack", a, 1'b0);
      wbyte(8'h80, a); check("cfgw_data_ack", a, 1'b0);
      i2c_stop();
      check("busy_stop", busy, 1'b0);
      check("cfgw_value", config_reg, 8'h80);

      temp_word = 16'h0C80;
      i2c_start();
      wbyte(8'h96, a);
      wbyte(8'h00, a); check("tmp_ptr_ack", a, 1'b0);
      i2c_start();
      wbyte(8'h97, a); check("tmp_raddr_ack", a, 1'b0);
      rbyte(d, 1'b0);  check("tmp_msb", d, 8'h0C);
      temp_word = 16'h1F00;
      rbyte(d, 1'b1);  check("tmp_lsb_snap", d, 8'h80);
      i2c_stop();
      check("tmp_release", sda_pull_low, 1'b0);

      temp_word = 16'h1F24;
      i2c_start();
      wbyte(8'h97, a); check("hold_addr_ack", a, 1'b0);
      rbyte(d, 1'b1);  check("hold_ptr_lsb", d, 8'h24);
      i2c_stop();

      i2c_start();
      wbyte(8'h90, a); check("bad_addr_nack", a, 1'b1);
      check("bad_release", sda_pull_low, 1'b0);
      wbyte(8'h03, a); check("bad_ptr_nack", a, 1'b1);
      wbyte(8'h11, a); check("bad_data_nack", a, 1'b1);
      i2c_stop();
      check("bad_cfg_kept", config_reg, 8'h80);

      read_ptr(8'h0B, 8'hCB, "rd_id");
      read_ptr(8'h02, 8'h80, "rd_status");
      read_ptr(8'h03, 8'h80, "rd_cfg");
      read_ptr(8'h05, 8'h00, "rd_other");

      i2c_start();
      wbyte(8'h96, a);
      wbyte(8'h0B, a);
      i2c_start();
      wbyte(8'h97, a);
      rbyte(d, 1'b0); check("id_burst0", d, 8'hCB);
      rbyte(d, 1'b1); check("id_burst1", d, 8'hCB);
      i2c_stop();

      i2c_start();
      wbyte(8'h96, a);
      wbyte(8'h03, a);
      wbyte(8'h11, a); check("multi_ack0", a, 1'b0);
      wbyte(8'h5A, a); check("multi_ack1", a, 1'b0);
      i2c_stop();
      check("multi_cfg", config_reg, 8'h5A);

      i2c_start();
      wbyte(8'h96, a);
      wbyte(8'h04, a);
      wbyte(8'h77, a); check("discard_ack", a, 1'b0);
      i2c_stop();
      check("discard_cfg", config_reg, 8'h5A);

      temp_word = 16'h0C80;
      i2c_start();
      wbyte(8'h96, a);
      wbyte(8'h00, a);
      i2c_start();
      wbyte(8'h97, a);
      check("mid_pull_before", sda_pull_low, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_pull_async", sda_pull_low, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy_rst", busy, 1'b0);
      check("mid_cfg_rst", config_reg, 8'h00);
      rst_n = 1'b1;
      qw();
      i2c_stop();

      i2c_start();
      wbyte(8'h97, a); check("post_addr_ack", a, 1'b0);
      rbyte(d, 1'b1);  check("post_msb", d, 8'h0C);
      i2c_stop();

      i2c_start();
      wbyte(8'h96, a);
      wbyte(8'h03, a);
      wbyte(8'hC3, a); check("post_wr_ack", a, 1'b0);
      i2c_stop();
      check("post_cfg", config_reg, 8'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adt7420_i2c_responder.md
ADT7420_I2C_RESPONDER -- requirements
Module: adt7420_i2c_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h4B, the 7-bit I2C target address matched after START.
REQ-002 SHALL have parameter DEVICE_ID, default 8'hCB, the value returned from register 0x0B.
REQ-003 clk_100MHz  input  1  system clock; the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  raw I2C SCL from pad; asynchronous to clk_100MHz.
REQ-006 sda_in  input  1  raw I2C SDA from pad; asynchronous to clk_100MHz.
REQ-007 sda_pull_low  output  1  open-drain drive: 1 pulls SDA low, 0 releases it.
REQ-008 temp_word  input  16  sensor value in ADT7420 register format, {MSB, LSB}.
REQ-009 config_reg  output  8  current configuration register value (register 0x03).
REQ-010 busy  output  1  high from a detected START until a detected STOP.

Function
REQ-011 SHALL pass scl_in and sda_in through 2-flop synchronizers, then a history flop for edge detection; the synchronized signals are used for all decisions.
REQ-012 START = SDA falling while SCL high; STOP = SDA rising while SCL high; each is a 1-cycle internal pulse.
REQ-013 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
REQ-014 A START (including a repeated START) from any state SHALL go to ADDR and clear the bit counter; a STOP from any state SHALL go to IDLE and release SDA.
REQ-015 Incoming bits SHALL be sampled MSB-first on SCL rising edges, 8 per byte, counted by a 3-bit counter.
REQ-016 ADDR: if byte[7:1] == DEV_ADDR, go to ADDR_ACK and ACK; otherwise go to IDLE with no ACK.
REQ-017 ACK and outgoing data bits SHALL change only on SCL falling edges; sda_pull_low SHALL be asserted on the falling edge that ends bit 8 and released on the following falling edge.
REQ-018 After an address ACK with R/W=0: PTR receives the pointer byte, ACKs it, then goes to WDATA.
REQ-019 After an address ACK with R/W=1: go to RDATA.
REQ-020 WDATA: if pointer == 0x03, the byte SHALL be written to config_reg, otherwise it is discarded; every byte SHALL be ACKed; the state then returns to WDATA.
REQ-021 On an address match with R/W=1, temp_word SHALL be captured into a shadow register on the ACK falling edge, so that MSB and LSB are coherent.
REQ-022 Read map: 0x00 = shadow[15:8]; 0x01 = shadow[7:0]; 0x02 = status 8'h80 (RDY_n=1 never asserted low); 0x03 = config_reg; 0x0B = DEVICE_ID; any other pointer = 8'h00.
REQ-023 RDATA: shift out 8 bits, release SDA, then in RACK sample the controller's bit on SCL rise.
REQ-024 RACK: ACK (0) SHALL go to RDATA with the pointer incremented if the pointer is 0x00; NACK (1) SHALL go to IDLE, waiting for STOP or START.
REQ-025 The pointer SHALL be 8 bits; auto-increment applies only from 0x00 to 0x01; all other pointers hold their value.
REQ-026 sda_pull_low SHALL never be asserted while SCL is high, except when holding an ACK or data bit across the high phase.

Reset
REQ-027 While rst_n = 0: state = IDLE, sda_pull_low = 0, busy = 0, config_reg = 8'h00, pointer = 8'h00, shadow = 0, synchronizers = 1 (bus idle).
REQ-028 A reset mid-transaction SHALL release SDA immediately and asynchronously; after reset the FSM SHALL wait for a new START.

Structure
REQ-029 A shared package adt7420_pkg SHALL hold the state enum and the register address constants (REG_TEMP_MSB, REG_TEMP_LSB, REG_STATUS, REG_CONFIG, REG_ID).
REQ-030 A single sub-module i2c_bus_sync SHALL provide synchronization and edge/START/STOP detection; the FSM and register file are in the top module.

Verification
REQ-031 Write to 0x4B, pointer 0x03, data 0x80, then STOP -> three ACKs, config_reg = 0x80.
REQ-032 Write to 0x4B, pointer 0x00, repeated START, read 2 bytes (ACK, NACK) with temp_word = 16'h0C80 -> bytes 0x0C then 0x80.
REQ-033 Change temp_word to 16'h1F00 between the MSB and LSB reads -> LSB still from the earlier snapshot (0x80).
REQ-034 Address 0x48 -> no ACK, SDA released, config_reg unchanged.
REQ-035 Pointer 0x0B read -> 0xCB; pointer 0x02 read -> 0x80.
REQ-036 Assert rst_n low during the data phase of a read -> sda_pull_low = 0 at once; the next valid transaction completes normally.
